fish_blob_track: RTL and testbench



---
 rtl/fish_pkg.sv | 19 +
 rtl/mask_run_filter.sv | 54 +++++
 rtl/fish_blob_track.sv | 165 ++++++++++++++++
 tb/tb_fish_blob_track.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fish_pkg.sv
// Shared types and constants for the blob tracker / fish counter.
package fish_pkg;
    localparam int COORD_W = 10;
    localparam int BLOB_W  = 9;
    localparam int RUN_W   = 8;
    localparam int FCNT_W  = 4;
    localparam int SPAN_W  = COORD_W + 1;

    localparam logic [COORD_W-1:0] COORD_MAX = 10'd1023;
    localparam logic [COORD_W-1:0] COORD_MIN = 10'd0;

    typedef enum logic [1:0] {IDLE, CONFIRM, TRACK, GONE_WAIT} trk_state_t;

    // Inclusive extent hi-lo+1, widened so a full-range box does not wrap.
    function automatic logic [SPAN_W-1:0] span(input logic [COORD_W-1:0] lo,
                                               input logic [COORD_W-1:0] hi);
        return {1'b0, hi} - {1'b0, lo} + SPAN_W'(1);
    endfunction
endpackage

// File: rtl/mask_run_filter.sv
// Horizontal run-length filter: flags mask pixels that sit in a run of at
// least MIN_RUN consecutive pixels on the same line.
module mask_run_filter
    import fish_pkg::*;
#(
    parameter int MIN_RUN = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_valid,
    input  logic               mask,
    input  logic [COORD_W-1:0] tv_x,
    input  logic [COORD_W-1:0] tv_y,
    output logic               hit,
    output logic               first_hit,
    output logic [COORD_W-1:0] run_x0,
    output logic [COORD_W-1:0] hit_y
);
    localparam logic [RUN_W:0] MIN_RUN_V = (RUN_W+1)'(MIN_RUN);

    logic [RUN_W-1:0]   run_len;
    logic [RUN_W-1:0]   base;
    logic [RUN_W:0]     run_inc;
    logic [COORD_W-1:0] run_x0_q;
    logic [COORD_W-1:0] last_y;

    // Run length as seen by this pixel: a line change restarts the run.
    always_comb begin
        base      = (tv_y != last_y) ? '0 : run_len;
        run_inc   = {1'b0, base} + (RUN_W+1)'(1);
        hit       = pix_valid & mask & (run_inc >= MIN_RUN_V);
        first_hit = pix_valid & mask & (run_inc == MIN_RUN_V);
        run_x0    = (base == '0) ? tv_x : run_x0_q;
        hit_y     = tv_y;
    end

    // Run state: saturating length, start column of the run, last line seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_len  <= '0;
            run_x0_q <= '0;
            last_y   <= '0;
        end else if (pix_valid) begin
            last_y <= tv_y;
            if (mask) begin
                run_len <= (base == '1) ? base : base + RUN_W'(1);
                if (base == '0)
                    run_x0_q <= tv_x;
            end else begin
                run_len <= '0;
            end
        end
    end
endmodule

// File: rtl/fish_blob_track.sv
// Per-frame bounding box of run-filtered mask pixels, blob presence test,
// and a confirm/absence FSM that counts each fish once as it leaves.
module fish_blob_track
    import fish_pkg::*;
#(
    parameter int MIN_RUN        = 3,
    parameter int CONFIRM_FRAMES = 2,
    parameter int ABSENT_FRAMES  = 3,
    parameter int COUNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_valid,
    input  logic               mask,
    input  logic [COORD_W-1:0] tv_x,
    input  logic [COORD_W-1:0] tv_y,
    input  logic               frame_end,
    input  logic [BLOB_W-1:0]  blob_min_x,
    input  logic [BLOB_W-1:0]  blob_min_y,
    output logic               blob_present,
    output logic [COORD_W-1:0] bbox_x0,
    output logic [COORD_W-1:0] bbox_x1,
    output logic [COORD_W-1:0] bbox_y0,
    output logic [COORD_W-1:0] bbox_y1,
    output logic [COUNT_W-1:0] fish_count,
    output logic               count_pulse,
    output logic               tracking
);
    localparam logic [FCNT_W-1:0] CONF_N = FCNT_W'(CONFIRM_FRAMES);
    localparam logic [FCNT_W-1:0] ABS_N  = FCNT_W'(ABSENT_FRAMES);

    logic               hit, first_hit;
    logic [COORD_W-1:0] run_x0, hit_y;

    logic [COORD_W-1:0] x0_q, x1_q, y0_q, y1_q;
    logic [COORD_W-1:0] x0_n, x1_n, y0_n, y1_n;
    logic               any_q, any_n;
    logic               present;

    trk_state_t         state_q, state_n;
    logic [FCNT_W-1:0]  fcnt_q, fcnt_n;
    logic               count_evt;

    mask_run_filter #(.MIN_RUN(MIN_RUN)) u_run (
        .clk       (clk),
        .rst       (rst),
        .pix_valid (pix_valid),
        .mask      (mask),
        .tv_x      (tv_x),
        .tv_y      (tv_y),
        .hit       (hit),
        .first_hit (first_hit),
        .run_x0    (run_x0),
        .hit_y     (hit_y)
    );

    // Box including this cycle's pixel, so a pixel on the frame_end cycle
    // still lands in the ending frame; presence is judged on that box.
    always_comb begin
        x0_n  = x0_q;
        x1_n  = x1_q;
        y0_n  = y0_q;
        y1_n  = y1_q;
        any_n = any_q;
        if (first_hit && run_x0 < x0_q)
            x0_n = run_x0;
        if (hit) begin
            if (tv_x > x1_q)  x1_n = tv_x;
            if (hit_y < y0_q) y0_n = hit_y;
            if (hit_y > y1_q) y1_n = hit_y;
            any_n = 1'b1;
        end
        present = any_n
                & (span(x0_n, x1_n) >= {2'b00, blob_min_x})
                & (span(y0_n, y1_n) >= {2'b00, blob_min_y});
    end

    // Accumulators: reload at reset and at every frame boundary.
    always_ff @(posedge clk) begin
        if (rst || frame_end) begin
            x0_q  <= COORD_MAX;
            y0_q  <= COORD_MAX;
            x1_q  <= COORD_MIN;
            y1_q  <= COORD_MIN;
            any_q <= 1'b0;
        end else begin
            x0_q  <= x0_n;
            x1_q  <= x1_n;
            y0_q  <= y0_n;
            y1_q  <= y1_n;
            any_q <= any_n;
        end
    end

    // Tracker next-state: advances only on frame_end.
    always_comb begin
        state_n   = state_q;
        fcnt_n    = fcnt_q;
        count_evt = 1'b0;
        if (frame_end) begin
            unique case (state_q)
                IDLE: if (present) begin
                    fcnt_n  = FCNT_W'(1);
                    state_n = (CONF_N == FCNT_W'(1)) ? TRACK : CONFIRM;
                end
                CONFIRM: if (present) begin
                    fcnt_n = fcnt_q + FCNT_W'(1);
                    if (fcnt_n == CONF_N) state_n = TRACK;
                end else begin
                    fcnt_n  = '0;
                    state_n = IDLE;
                end
                TRACK: if (!present) begin
                    fcnt_n = FCNT_W'(1);
                    if (ABS_N == FCNT_W'(1)) begin
                        count_evt = 1'b1;
                        state_n   = IDLE;
                    end else begin
                        state_n = GONE_WAIT;
                    end
                end
                GONE_WAIT: if (present) begin
                    state_n = TRACK;
                end else begin
                    fcnt_n = fcnt_q + FCNT_W'(1);
                    if (fcnt_n == ABS_N) begin
                        count_evt = 1'b1;
                        state_n   = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // State, frame result registers and the saturating fish counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            fcnt_q       <= '0;
            blob_present <= 1'b0;
            bbox_x0      <= '0;
            bbox_x1      <= '0;
            bbox_y0      <= '0;
            bbox_y1      <= '0;
            fish_count   <= '0;
            count_pulse  <= 1'b0;
        end else begin
            state_q     <= state_n;
            fcnt_q      <= fcnt_n;
            count_pulse <= count_evt;
            if (frame_end) begin
                blob_present <= present;
                bbox_x0      <= any_n ? x0_n : '0;
                bbox_x1      <= any_n ? x1_n : '0;
                bbox_y0      <= any_n ? y0_n : '0;
                bbox_y1      <= any_n ? y1_n : '0;
            end
            if (count_evt && fish_count != '1)
                fish_count <= fish_count + COUNT_W'(1);
        end
    end

    assign tracking = (state_q == TRACK) || (state_q == GONE_WAIT);
endmodule

// File: tb/tb_fish_blob_track.sv
// Scoreboard bench for fish_blob_track: expected per-frame results are
// queued when frame_end is driven and compared the cycle after.
module tb_fish_blob_track;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst, pix_valid, mask, frame_end;
    logic [9:0]    tv_x, tv_y;
    logic [8:0]    blob_min_x, blob_min_y;
    logic          blob_present, count_pulse, tracking;
    logic [9:0]    bbox_x0, bbox_x1, bbox_y0, bbox_y1;
    logic [CW-1:0] fish_count;

    always #5 clk = ~clk;

    fish_blob_track #(.MIN_RUN(3), .CONFIRM_FRAMES(2), .ABSENT_FRAMES(3), .COUNT_W(CW)) dut (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .mask(mask), .tv_x(tv_x), .tv_y(tv_y),
        .frame_end(frame_end), .blob_min_x(blob_min_x), .blob_min_y(blob_min_y),
        .blob_present(blob_present), .bbox_x0(bbox_x0), .bbox_x1(bbox_x1),
        .bbox_y0(bbox_y0), .bbox_y1(bbox_y1), .fish_count(fish_count),
        .count_pulse(count_pulse), .tracking(tracking)
    );

    typedef struct {
        logic       pres;
        logic [9:0] x0, x1, y0, y1;
        logic       trk;
        logic [3:0] cnt;
        logic       pulse;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic fe_seen = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic p, input int x0, x1, y0, y1,
                                input logic trk, input int cnt, input logic pulse);
        exp_t e;
        e.pres = p; e.x0 = 10'(x0); e.x1 = 10'(x1); e.y0 = 10'(y0); e.y1 = 10'(y1);
        e.trk = trk; e.cnt = 4'(cnt); e.pulse = pulse;
        return e;
    endfunction

    // Registered outputs reflect a frame_end one edge later.
    always @(posedge clk) fe_seen <= frame_end & ~rst;

    // Output monitor: compare each finished frame; no pulse elsewhere.
    always @(negedge clk) begin
        if (fe_seen) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("present", blob_present, mon_e.pres);
                chk("bbox_x0", bbox_x0, mon_e.x0);
                chk("bbox_x1", bbox_x1, mon_e.x1);
                chk("bbox_y0", bbox_y0, mon_e.y0);
                chk("bbox_y1", bbox_y1, mon_e.y1);
                chk("tracking", tracking, mon_e.trk);
                chk("fish_count", fish_count, mon_e.cnt);
                chk("count_pulse", count_pulse, mon_e.pulse);
            end
        end else if (count_pulse) begin
            chk("stray_pulse", count_pulse, 0);
        end
    end

    task automatic drive_px(input logic m, input int x, input int y);
        @(negedge clk);
        pix_valid = 1'b1; mask = m; tv_x = 10'(x); tv_y = 10'(y);
    endtask

    // Frame end with optional same-cycle pixel; minimums are only valid
    // on this cycle and deliberately scrambled otherwise.
    task automatic end_frame(input logic hv, input logic m, input int x, input int y,
                             input int mnx, input int mny, input exp_t e);
        sb.push_back(e);
        @(negedge clk);
        pix_valid = hv; mask = m; tv_x = 10'(x); tv_y = 10'(y);
        frame_end = 1'b1; blob_min_x = 9'(mnx); blob_min_y = 9'(mny);
        @(negedge clk);
        pix_valid = 1'b0; mask = 1'b0; frame_end = 1'b0;
        blob_min_x = ~blob_min_x; blob_min_y = ~blob_min_y;
        @(negedge clk);
    endtask

    task automatic empty_frame(input logic trk, input int cnt, input logic pulse);
        end_frame(1'b0, 1'b0, 0, 0, 21, 15, mk(1'b0, 0, 0, 0, 0, trk, cnt, pulse));
    endtask

    // Solid rectangle, each line led by a mask=0 pixel; last pixel rides frame_end.
    task automatic rect_frame(input int x0, x1, y0, y1, mnx, mny,
                              input logic p, input logic trk, input int cnt, input logic pulse);
        for (int y = y0; y <= y1; y++)
            for (int x = x0 - 1; x <= x1; x++)
                if (y == y1 && x == x1)
                    end_frame(1'b1, 1'b1, x, y, mnx, mny, mk(p, x0, x1, y0, y1, trk, cnt, pulse));
                else
                    drive_px(x >= x0, x, y);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_present"}, blob_present, 0);
        chk({tag, "_x0"}, bbox_x0, 0);
        chk({tag, "_x1"}, bbox_x1, 0);
        chk({tag, "_y0"}, bbox_y0, 0);
        chk({tag, "_y1"}, bbox_y1, 0);
        chk({tag, "_count"}, fish_count, 0);
        chk({tag, "_pulse"}, count_pulse, 0);
        chk({tag, "_tracking"}, tracking, 0);
    endtask

    initial begin
        int prev;
        rst = 1'b1; pix_valid = 1'b0; mask = 1'b0; frame_end = 1'b0;
        tv_x = '0; tv_y = '0; blob_min_x = '0; blob_min_y = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;
        @(negedge clk);

        // Fish: 40x30 rectangle for two frames, then three empty frames.
        rect_frame(100, 139, 50, 79, 21, 15, 1'b1, 1'b0, 0, 1'b0);
        rect_frame(100, 139, 50, 79, 21, 15, 1'b1, 1'b1, 0, 1'b0);
        empty_frame(1'b1, 0, 1'b0);
        empty_frame(1'b1, 0, 1'b0);
        empty_frame(1'b0, 1, 1'b1);

        // Two-pixel runs only, plus a four-pixel run split across a line.
        drive_px(1, 5, 10);    drive_px(1, 6, 10);   drive_px(0, 7, 10);
        drive_px(1, 8, 10);    drive_px(1, 9, 10);   drive_px(0, 10, 10);
        drive_px(1, 1021, 11); drive_px(1, 1022, 11);
        drive_px(1, 0, 12);    drive_px(1, 1, 12);
        end_frame(1'b1, 1'b0, 2, 12, 1, 1, mk(1'b0, 0, 0, 0, 0, 1'b0, 1, 1'b0));

        // Width threshold boundary: 20 wide fails min 21, passes min 20.
        rect_frame(200, 219, 300, 329, 21, 15, 1'b0, 1'b0, 1, 1'b0);
        rect_frame(200, 219, 300, 329, 20, 15, 1'b1, 1'b0, 1, 1'b0);
        empty_frame(1'b0, 1, 1'b0);

        // Fish that briefly vanishes and returns: counted once.
        rect_frame(10, 19, 5, 7, 5, 2, 1'b1, 1'b0, 1, 1'b0);
        rect_frame(10, 19, 5, 7, 5, 2, 1'b1, 1'b1, 1, 1'b0);
        empty_frame(1'b1, 1, 1'b0);
        rect_frame(10, 19, 5, 7, 5, 2, 1'b1, 1'b1, 1, 1'b0);
        empty_frame(1'b1, 1, 1'b0);
        empty_frame(1'b1, 1, 1'b0);
        empty_frame(1'b0, 2, 1'b1);

        // Drive the counter to saturation and one fish beyond.
        for (int i = 3; i <= 16; i++) begin
            prev = (i - 1 > 15) ? 15 : i - 1;
            rect_frame(40, 42, 8, 8, 1, 1, 1'b1, 1'b0, prev, 1'b0);
            rect_frame(40, 42, 8, 8, 1, 1, 1'b1, 1'b1, prev, 1'b0);
            empty_frame(1'b1, prev, 1'b0);
            empty_frame(1'b1, prev, 1'b0);
            empty_frame(1'b0, (i > 15) ? 15 : i, 1'b1);
        end

        // Reset mid-frame while tracking; next frame uses post-reset pixels only.
        rect_frame(40, 42, 8, 8, 1, 1, 1'b1, 1'b0, 15, 1'b0);
        rect_frame(40, 42, 8, 8, 1, 1, 1'b1, 1'b1, 15, 1'b0);
        for (int x = 10; x < 20; x++) drive_px(1, x, 5);
        @(negedge clk);
        rst = 1'b1; pix_valid = 1'b1; mask = 1'b1; tv_x = 10'd20; tv_y = 10'd5;
        @(negedge clk);
        rst = 1'b0; pix_valid = 1'b0; mask = 1'b0;
        check_reset_outputs("midrst");
        rect_frame(200, 229, 100, 104, 5, 5, 1'b1, 1'b0, 0, 1'b0);
        empty_frame(1'b0, 0, 1'b0);

        repeat (2) @(negedge clk);
        chk("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
